axis_64to32_strb_tuser: RTL and testbench

//  Serialises a 64-bit AXI-Stream with TSTRB/TUSER into a 32-bit AXI-Stream.

---
 rtl/axis_64to32_strb_tuser.sv | 168 ++++++++++++++++
 tb/tb_axis_64to32_strb_tuser.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_64to32_strb_tuser.sv
// axis_64to32_strb_tuser
// Serialises a 64-bit AXI-Stream carrying TSTRB/TUSER into a 32-bit AXI-Stream.
// Each packet starts with its TUSER as a 32-bit header word. After that, every
// beat is sent as its low 32-bit word and then its high 32-bit word.
// A half beat (TSTRB[7:4]==0) sends only its low word.
// A header-only first beat (TSTRB==0) sends only the header word.
//
// Ports
//   AXIS_ACLK, AXIS_ARESETN      clock; asynchronous active-low reset
//   S_AXIS_T{VALID,READY,DATA,STRB,LAST,USER}   64-bit input stream
//   M_AXIS_T{VALID,READY,DATA,LAST}             32-bit output stream
//   STRB_ERR                     sticky strobe-error flag. This port exists only
//                                when AXIS_64TO32_STRB_ERR_EN is defined.
//
// Optional feature macro: AXIS_64TO32_STRB_ERR_EN
module axis_64to32_strb_tuser (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic [7:0]  S_AXIS_TSTRB,
  input  logic        S_AXIS_TLAST,
  input  logic [31:0] S_AXIS_TUSER,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST
`ifdef AXIS_64TO32_STRB_ERR_EN
  ,
  output logic        STRB_ERR
`endif
);

  typedef enum logic [1:0] {StIdle, StHdr, StLsb, StMsb} state_e;

  state_e      state_q, state_d;
  logic [63:0] data_q;
  logic [31:0] tuser_q;
  logic        half_q, zero_q, last_q, full_q, sof_q;

  logic        final_word, m_xfr, final_xfr, s_xfr;
  logic        new_half, new_zero;
  logic [63:0] src_data;
  logic [31:0] src_tuser;
  logic        src_half, src_zero, src_last;
  logic        tvalid_d, tlast_d;
  logic [31:0] tdata_d;

  // Is the word currently on the output the last one this held beat produces?
  always_comb begin
    final_word = 1'b0;
    case (state_q)
      StHdr:   final_word = zero_q;
      StLsb:   final_word = half_q;
      StMsb:   final_word = 1'b1;
      default: final_word = 1'b0;
    endcase
  end

  assign m_xfr     = M_AXIS_TVALID & M_AXIS_TREADY;
  assign final_xfr = m_xfr & final_word;
  // The register can refill on the same edge that its final word leaves.
  assign S_AXIS_TREADY = AXIS_ARESETN & (~full_q | final_xfr);
  assign s_xfr     = S_AXIS_TVALID & S_AXIS_TREADY;

  // A zero strobe on a non-sof beat decodes as half, because its upper nibble is also zero.
  assign new_half = (S_AXIS_TSTRB[7:4] == 4'h0);
  assign new_zero = sof_q & (S_AXIS_TSTRB == 8'h00);

  // Take the next output word from the incoming beat when one is accepted, otherwise from the held beat.
  assign src_data  = s_xfr ? S_AXIS_TDATA : data_q;
  assign src_tuser = (s_xfr & sof_q) ? S_AXIS_TUSER : tuser_q;
  assign src_half  = s_xfr ? new_half : half_q;
  assign src_zero  = s_xfr ? new_zero : zero_q;
  assign src_last  = s_xfr ? S_AXIS_TLAST : last_q;

  always_comb begin
    state_d = state_q;
    if (s_xfr) begin
      state_d = sof_q ? StHdr : StLsb;
    end else if (final_xfr) begin
      state_d = StIdle;
    end else if (m_xfr) begin
      state_d = (state_q == StHdr) ? StLsb : StMsb;
    end
  end

  always_comb begin
    tvalid_d = 1'b1;
    tdata_d  = 32'h0;
    tlast_d  = 1'b0;
    case (state_d)
      StHdr: begin
        tdata_d = src_tuser;
        tlast_d = src_last & src_zero;
      end
      StLsb: begin
        tdata_d = src_data[31:0];
        tlast_d = src_last & src_half;
      end
      StMsb: begin
        tdata_d = src_data[63:32];
        tlast_d = src_last;
      end
      default: tvalid_d = 1'b0;
    endcase
  end

`ifdef AXIS_64TO32_STRB_ERR_EN
  logic strb_bad;
  always_comb begin
    strb_bad = 1'b0;
    if (!(S_AXIS_TSTRB == 8'hff || S_AXIS_TSTRB == 8'h0f || S_AXIS_TSTRB == 8'h00)) begin
      strb_bad = 1'b1;
    end
    if (S_AXIS_TSTRB == 8'h00 && !sof_q) begin
      strb_bad = 1'b1;
    end
    if ((S_AXIS_TSTRB == 8'h0f || S_AXIS_TSTRB == 8'h00) && !S_AXIS_TLAST) begin
      strb_bad = 1'b1;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      STRB_ERR <= 1'b0;
    end else if (s_xfr && strb_bad) begin
      STRB_ERR <= 1'b1;
    end
  end
`endif

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q       <= StIdle;
      data_q        <= 64'h0;
      tuser_q       <= 32'h0;
      half_q        <= 1'b0;
      zero_q        <= 1'b0;
      last_q        <= 1'b0;
      full_q        <= 1'b0;
      sof_q         <= 1'b1;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= 32'h0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      state_q       <= state_d;
      M_AXIS_TVALID <= tvalid_d;
      M_AXIS_TDATA  <= tdata_d;
      M_AXIS_TLAST  <= tlast_d;
      if (s_xfr) begin
        data_q <= S_AXIS_TDATA;
        if (sof_q) begin
          tuser_q <= S_AXIS_TUSER;
        end
        half_q <= new_half;
        zero_q <= new_zero;
        last_q <= S_AXIS_TLAST;
        full_q <= 1'b1;
        sof_q  <= S_AXIS_TLAST;
      end else if (final_xfr) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_64to32_strb_tuser.sv
// tb_axis_64to32_strb_tuser
// Testbench for axis_64to32_strb_tuser. It drives directed packets and checks
// each output word against a hand-computed expected list.
module tb_axis_64to32_strb_tuser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic [31:0] s_tuser;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
`ifdef AXIS_64TO32_STRB_ERR_EN
  logic        strb_err;
`endif

  always #5 clk = ~clk;

  axis_64to32_strb_tuser dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TSTRB (s_tstrb),
    .S_AXIS_TLAST (s_tlast),
    .S_AXIS_TUSER (s_tuser),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TLAST (m_tlast)
`ifdef AXIS_64TO32_STRB_ERR_EN
    ,
    .STRB_ERR     (strb_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;
  bit rand_ready = 1'b0;
  logic [32:0] got_q[$];
  int          got_cyc[$];
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Words are captured half a cycle before the edge that transfers them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        got_cyc.push_back(cyc);
      end
      if (m_tvalid && !m_tready && s_tready) viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] st, input logic l,
                           input logic [31:0] u);
    bit acc = 1'b0;
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = l;
    s_tuser  = u;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_tready;
      step();
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_beat timeout got=no-accept want=accept");
    end
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    s_tvalid = 1'b0;
    while (got_q.size() < n && k < 5000) begin
      step();
      k++;
    end
    repeat (3) step();
    total++;
    if (got_q.size() != n) begin
      bad++;
      $display("FAIL word_count got=%0d want=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tstrb = '0;
    s_tlast = 1'b0;
    s_tuser = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", m_tvalid); end
    if (m_tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h want=0", m_tdata); end
    if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", m_tlast); end
    if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", s_tready); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_tready !== 1'b1) begin bad++; $display("FAIL post_rst_tready got=%b want=1", s_tready); end
    step();
  endtask

  task automatic test_full_beats();
    clear_q();
    m_tready = 1'b1;
    exp_q = '{{1'b0, 32'hA5A50001}, {1'b0, 32'h11111111}, {1'b0, 32'h22222222},
              {1'b0, 32'h33333333}, {1'b1, 32'h44444444}};
    send_beat(64'h22222222_11111111, 8'hff, 1'b0, 32'hA5A50001);
    send_beat(64'h44444444_33333333, 8'hff, 1'b1, 32'hDEADDEAD);
    wait_words(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL full_word%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (got_cyc.size() == 5 && (got_cyc[4] - got_cyc[0]) != 4) begin
      bad++;
      $display("FAIL full_no_bubble got=%0d want=4", got_cyc[4] - got_cyc[0]);
    end
  endtask

  task automatic test_half_beat();
    int seen = 0;
    clear_q();
    m_tready = 1'b1;
    exp_q = '{{1'b0, 32'h0000BEEF}, {1'b0, 32'hAAAA0001}, {1'b0, 32'h55550002},
              {1'b1, 32'hCCCC0003}};
    send_beat(64'h55550002_AAAA0001, 8'hff, 1'b0, 32'h0000BEEF);
    send_beat(64'h0BAD0BAD_CCCC0003, 8'h0f, 1'b1, 32'h0);
    wait_words(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL half_word%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    foreach (got_q[i]) if (got_q[i][31:0] == 32'h0BAD0BAD) seen++;
    total++;
    if (seen != 0) begin bad++; $display("FAIL half_msw_leak got=%0d want=0", seen); end
  endtask

  task automatic test_header_only();
    clear_q();
    m_tready = 1'b1;
    send_beat(64'hFFFFFFFF_EEEEEEEE, 8'h00, 1'b1, 32'h12345678);
    wait_words(1);
    total++;
    if (got_q[0] !== {1'b1, 32'h12345678}) begin
      bad++;
      $display("FAIL hdr_only got=%h want=%h", got_q[0], {1'b1, 32'h12345678});
    end
  endtask

  task automatic test_random();
    int len, r;
    logic [63:0] d;
    logic [31:0] u;
    logic [7:0] st;
    logic l, hf, zr;
    clear_q();
    viol = 0;
    rand_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 4);
      u = $urandom;
      for (int b = 0; b < len; b++) begin
        l = (b == len - 1);
        d = {$urandom, $urandom};
        st = 8'hff;
        if (l) begin
          r = $urandom_range(0, 2);
          st = (r == 1) ? 8'h0f : ((r == 2 && len == 1) ? 8'h00 : 8'hff);
        end
        hf = (st[7:4] == 4'h0);
        zr = (b == 0) && (st == 8'h00);
        if (b == 0) exp_q.push_back({l & zr, u});
        if (!zr) begin
          exp_q.push_back({l & hf, d[31:0]});
          if (!hf) exp_q.push_back({l, d[63:32]});
        end
        send_beat(d, st, l, u);
      end
    end
    s_tvalid = 1'b0;
    rand_ready = 1'b0;
    m_tready = 1'b1;
    wait_words(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_word%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL rand_tready_rule got=%0d want=0", viol); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    m_tready = 1'b0;
    send_beat(64'h9999AAAA_77778888, 8'hff, 1'b0, 32'hAAAA0000);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h9999AAAA) begin
      bad++;
      $display("FAIL mid_msb got=%b/%h want=1/9999aaaa", m_tvalid, m_tdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total += 2;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid got=%b want=0", m_tvalid); end
    if (s_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_tready got=%b want=0", s_tready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
    m_tready = 1'b1;
    exp_q = '{{1'b0, 32'hB0B0B0B0}, {1'b0, 32'h00000001}, {1'b1, 32'h00000002}};
    send_beat(64'h00000002_00000001, 8'hff, 1'b1, 32'hB0B0B0B0);
    wait_words(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL mid_b_word%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef AXIS_64TO32_STRB_ERR_EN
  task automatic test_strb_err();
    clear_q();
    m_tready = 1'b1;
    total++;
    if (strb_err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", strb_err); end
    send_beat(64'h66666666_55555555, 8'h3c, 1'b1, 32'hC0DE0001);
    s_tvalid = 1'b0;
    total++;
    if (strb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", strb_err); end
    exp_q = '{{1'b0, 32'hC0DE0001}, {1'b0, 32'h55555555}, {1'b1, 32'h66666666}};
    wait_words(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL err_word%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    repeat (5) step();
    total++;
    if (strb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", strb_err); end
    rst_n = 1'b0;
    #1;
    total++;
    if (strb_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", strb_err); end
    step();
    rst_n = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_full_beats();
    test_half_beat();
    test_header_only();
    test_random();
    test_reset_mid();
`ifdef AXIS_64TO32_STRB_ERR_EN
    test_strb_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
